// File: rtl/addsub_share_ctrl.sv
// addsub_share_ctrl
// -----------------
// Round-robin controller that time-shares one multi-cycle add/subtract unit
// among N requesters. The winner's operands are latched and held stable while
// the unit runs for RUN_CYCLES enabled cycles. The result is captured on the
// first u_ready in WAIT and returned with a one-cycle done pulse.
//
// Optional feature macro: ADDSUB_WATCHDOG_EN
//   When defined, WAIT gives up after TIMEOUT cycles without u_ready. It then
//   reports done with err=1 and result=0, and re-enters INIT to re-sync the unit.
//   When undefined, WAIT waits indefinitely and err is tied low.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   req[N]          per-requester request level
//   a_in, b_in      packed operands, slice i = requester i
//   mod_in[N]       per-requester op select (0 = A+B, 1 = A-B)
//   gnt[N]          one-hot grant, held from arbitration through the done cycle
//   done[N]         one-hot one-cycle completion pulse
//   result[W]       captured unit result, held until the next done
//   err             timeout flag, asserted with done (watchdog build only)
//   u_a, u_b, u_mod operands/op select driven to the unit
//   u_en, u_rst     unit enable / reset (u_rst acts only while u_en=1)
//   u_c, u_ready    unit result and ready level
//   dbg_state       current FSM state (INIT=0, IDLE=1, RUN=2, WAIT=3, DONE=4)
//
// Handshake: a request is a level. It is sampled only in IDLE. Once granted,
// the requester's operands have been captured, and req/a_in/b_in/mod_in are
// ignored until done[winner] pulses. A requester that keeps req high after its
// done pulse is treated as a new request.

module addsub_share_ctrl #(
  parameter int N          = 4,
  parameter int W          = 3,
  parameter int RUN_CYCLES = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  input  logic [N-1:0]   mod_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   result,
  output logic           err,
  output logic [W-1:0]   u_a,
  output logic [W-1:0]   u_b,
  output logic           u_mod,
  output logic           u_en,
  output logic           u_rst,
  input  logic [W-1:0]   u_c,
  input  logic           u_ready,
  output logic [2:0]     dbg_state
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(RUN_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (N < 2 || N > 8 || W < 1 || RUN_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("addsub_share_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [W-1:0]    u_a_q, u_a_d;
  logic [W-1:0]    u_b_q, u_b_d;
  logic            u_mod_q, u_mod_d;
  logic [W-1:0]    result_q, result_d;
  logic [CW-1:0]   run_cnt_q, run_cnt_d;
`ifdef ADDSUB_WATCHDOG_EN
  logic            err_q, err_d;
  logic [TW-1:0]   wd_cnt_q, wd_cnt_d;
`endif

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [N-1:0]    win_oh;

  // Round-robin pick: first set req bit at or after ptr_q, wrapping mod N.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_valid && req[(int'(ptr_q) + k) % N]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign win_oh = {{(N-1){1'b0}}, 1'b1} << win_q;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      ptr_q     <= '0;
      win_q     <= '0;
      u_a_q     <= '0;
      u_b_q     <= '0;
      u_mod_q   <= 1'b0;
      result_q  <= '0;
      run_cnt_q <= '0;
`ifdef ADDSUB_WATCHDOG_EN
      err_q     <= 1'b0;
      wd_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      u_a_q     <= u_a_d;
      u_b_q     <= u_b_d;
      u_mod_q   <= u_mod_d;
      result_q  <= result_d;
      run_cnt_q <= run_cnt_d;
`ifdef ADDSUB_WATCHDOG_EN
      err_q     <= err_d;
      wd_cnt_q  <= wd_cnt_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    u_a_d     = u_a_q;
    u_b_d     = u_b_q;
    u_mod_d   = u_mod_q;
    result_d  = result_q;
    run_cnt_d = run_cnt_q;
`ifdef ADDSUB_WATCHDOG_EN
    err_d     = err_q;
    wd_cnt_d  = wd_cnt_q;
`endif
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (pick_valid) begin
          state_d   = S_RUN;
          win_d     = pick_idx;
          ptr_d     = (int'(pick_idx) == N - 1) ? '0 : pick_idx + PW'(1);
          u_a_d     = a_in[int'(pick_idx)*W +: W];
          u_b_d     = b_in[int'(pick_idx)*W +: W];
          u_mod_d   = mod_in[pick_idx];
          run_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (run_cnt_q == CW'(RUN_CYCLES - 1)) begin
          state_d = S_WAIT;
`ifdef ADDSUB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end else begin
          run_cnt_d = run_cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        // Any ready left over from a previous op was cleared by the unit
        // during RUN, so the first ready seen here belongs to this op.
        if (u_ready) begin
          result_d = u_c;
          state_d  = S_DONE;
        end
`ifdef ADDSUB_WATCHDOG_EN
        else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
`endif
      end
      S_DONE: begin
`ifdef ADDSUB_WATCHDOG_EN
        // After a timeout, the unit's phase is unknown, so it is re-aligned via INIT.
        state_d = err_q ? S_INIT : S_IDLE;
        err_d   = 1'b0;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    gnt   = '0;
    done  = '0;
    u_en  = 1'b0;
    u_rst = 1'b0;
    case (state_q)
      S_INIT: begin
        u_en  = 1'b1;
        u_rst = 1'b1;
      end
      S_RUN: begin
        u_en = 1'b1;
        gnt  = win_oh;
      end
      S_WAIT: gnt = win_oh;
      S_DONE: begin
        gnt  = win_oh;
        done = win_oh;
      end
      default: ;
    endcase
  end

  assign u_a       = u_a_q;
  assign u_b       = u_b_q;
  assign u_mod     = u_mod_q;
  assign result    = result_q;
  assign dbg_state = state_q;
`ifdef ADDSUB_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/addsub_share_ctrl.md
# addsub_share_ctrl

Round-robin controller that time-shares the single multi-cycle add/subtract unit among N requesters in the echo-cancellation datapath. It latches the winning requester's operands, sequences the unit's enable/reset for exactly one operation, and captures the result. It returns the result to the winner with a one-cycle done pulse. The block sits between the per-tap update logic and the shared add/sub instance.

## Interface
- N, 4: number of requesters (2..8).
- W, 3: operand/result width; equals the add/sub unit width.
- RUN_CYCLES, 4: enable cycles per unit operation.
- TIMEOUT, 8: wait-for-ready limit in cycles (used only with watchdog).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  per-requester request level.
- a_in  in  N*W  packed operand A; slice i belongs to requester i.
- b_in  in  N*W  packed operand B.
- mod_in  in  N  per-requester op select: 0 = A+B, 1 = A−B.
- gnt  out  N  one-hot grant, held from arbitration through the done cycle.
- done  out  N  one-hot, one-cycle completion pulse.
- result  out  W  unit result; valid in the done cycle and held until the next done.
- err  out  1  asserted with done when the operation timed out (watchdog only).
- u_a, u_b  out  W  operands to the unit.
- u_mod  out  1  op select to the unit.
- u_en  out  1  unit enable.
- u_rst  out  1  unit reset; effective only while u_en=1.
- u_c  in  W  unit result.
- u_ready  in  1  unit ready level.

## Operation
- States: INIT, IDLE, RUN, WAIT, DONE.
- Reset values:
  - gnt=0, done=0, result=0, err=0.
  - u_a=0, u_b=0, u_mod=0.
  - u_en=1, u_rst=1, so the unit phase counter clears together with this block.
  - State=INIT, RR pointer=0, counters=0.
- INIT: u_en=1, u_rst=1 for one cycle after rst deasserts, then IDLE.
- IDLE: u_en=0, u_rst=0. If any req is set:
  - Pick the first set bit at or after the pointer, wrapping modulo N.
  - Latch that requester's a/b/mod into u_a/u_b/u_mod.
  - Set gnt, go to RUN.
  - Move the pointer to winner+1 mod N.
  - If req is 0, stay in IDLE.
- RUN: u_en=1 for exactly RUN_CYCLES cycles; operands stay stable throughout, because the unit samples A at its first phase and A,B at its last. Then go to WAIT.
- WAIT: u_en=0. On the first cycle with u_ready=1, latch u_c into the result register and go to DONE.
  - Stale ready from a prior op is cleared by the unit in RUN and never seen here.
- DONE: done[winner]=1 for one cycle, gnt cleared at the end of the cycle, return to IDLE.
- A req still high after done is a new request; the rotated pointer gives other pending requesters priority first.
- req changes after grant are ignored until IDLE.
- Arithmetic is performed by the unit and wraps modulo 2^W; no saturation.
- rst mid-operation: immediate return to reset values; the in-flight op is dropped with no done pulse; INIT re-aligns the unit.

## Timing
- Cycle 0: IDLE samples req. Cycles 1..4: RUN, gnt high, u_en high. Cycle 5: WAIT sees u_ready. Cycle 6: DONE pulse, result valid.
- Request-to-done latency = RUN_CYCLES+2 cycles (6 by default), assuming the request is sampled in IDLE.
- Back-to-back throughput: one op per RUN_CYCLES+3 cycles (IDLE, RUN, WAIT, DONE).
- done and gnt never assert for two requesters at once; gnt is one-hot or zero.

## Configuration
- ADDSUB_WATCHDOG_EN defined:
  - WAIT counts cycles. If u_ready has not been seen after TIMEOUT cycles, go to DONE with done[winner]=1, err=1, result=0.
  - Then enter INIT instead of IDLE to re-sync the unit.
  - err clears on the next cycle.
- ADDSUB_WATCHDOG_EN undefined: WAIT waits indefinitely; err is tied to 0.

## Test plan
- Single request: req=0001, a0=3, b0=2, mod0=0 → gnt=0001 in cycles 1–6, done=0001 in cycle 6, result=5, err=0.
- Subtraction wrap: a=1, b=3, mod=1 → result=6 (mod 8).
- Contention: req=1111 held high, operands distinct per requester → done order 0,1,2,3,0, each 7 cycles apart, each result correct.
- Rotation fairness: after requester 2 wins, req=0101 → requester 0 is not starved and requester 2 goes after 0; grant order 0 then 2.
- Reset mid-RUN: assert rst in cycle 3 → outputs return to reset values with u_en=u_rst=1, no done pulse; INIT follows, then a new request completes correctly.
- Watchdog (with ADDSUB_WATCHDOG_EN): hold u_ready=0 → done with err=1 and result=0 exactly TIMEOUT cycles after WAIT entry, then one INIT cycle.
